// File: rtl/synverll_sdiv_pipe_if.sv
// ---------------------------------------------------------------------------
// synverll_sdiv_pipe_if
//   Call interface of the pipelined divider. The requester (master) presents
//   one operation per cycle; the divider (slave) returns results in order.
//
//   Signals:
//     __call_sdiv_req       master->slave  operation valid this cycle
//     __call_sdiv_ready     slave->master  always 1 (no backpressure)
//     __call_sdiv_signed    master->slave  1 = two's-complement operands
//     __call_sdiv_args_0    master->slave  dividend  [WIDTH]
//     __call_sdiv_args_1    master->slave  divisor   [WIDTH]
//     __call_sdiv_tag       master->slave  caller tag [TAG_W]
//     __call_sdiv_done      slave->master  one-cycle result pulse
//     __call_sdiv_q         slave->master  quotient  [WIDTH]
//     __call_sdiv_r         slave->master  remainder [WIDTH]
//     __call_sdiv_dbz       slave->master  divisor was zero
//     __call_sdiv_tag_out   slave->master  tag of completing op [TAG_W]
// ---------------------------------------------------------------------------
interface synverll_sdiv_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  logic             __call_sdiv_req;
  logic             __call_sdiv_ready;
  logic             __call_sdiv_signed;
  logic [WIDTH-1:0] __call_sdiv_args_0;
  logic [WIDTH-1:0] __call_sdiv_args_1;
  logic [TAG_W-1:0] __call_sdiv_tag;
  logic             __call_sdiv_done;
  logic [WIDTH-1:0] __call_sdiv_q;
  logic [WIDTH-1:0] __call_sdiv_r;
  logic             __call_sdiv_dbz;
  logic [TAG_W-1:0] __call_sdiv_tag_out;

  modport master (
    output __call_sdiv_req, __call_sdiv_signed, __call_sdiv_args_0,
           __call_sdiv_args_1, __call_sdiv_tag,
    input  __call_sdiv_ready, __call_sdiv_done, __call_sdiv_q,
           __call_sdiv_r, __call_sdiv_dbz, __call_sdiv_tag_out
  );

  modport slave (
    input  __call_sdiv_req, __call_sdiv_signed, __call_sdiv_args_0,
           __call_sdiv_args_1, __call_sdiv_tag,
    output __call_sdiv_ready, __call_sdiv_done, __call_sdiv_q,
           __call_sdiv_r, __call_sdiv_dbz, __call_sdiv_tag_out
  );
endinterface

// File: rtl/synverll_sdiv_pipe.sv
// ---------------------------------------------------------------------------
// synverll_sdiv_pipe
//   Fully pipelined signed/unsigned integer divider, one operation per clock,
//   fixed latency of WIDTH+2 clocks from req sample to done.
//
//   Pipeline ranks:
//     0            input register: operand magnitudes and result signs
//     1..WIDTH     restoring radix-2 steps, one quotient bit per rank
//     WIDTH+1      sign fix-up and divide-by-zero override
//     WIDTH+2      output register (the only externally visible rank)
//
//   Ports:
//     system_clock  clock, rising edge
//     system_reset  synchronous active-high reset
//     sdiv          call interface (slave side), see synverll_sdiv_pipe_if
// ---------------------------------------------------------------------------
module synverll_sdiv_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic               system_clock,
  input  logic               system_reset,
  synverll_sdiv_pipe_if.slave sdiv
);

  localparam int LATENCY    = WIDTH + 2;
  // Two ranks beyond the division steps: sign fix-up and output register.
  localparam int DIV_STAGES = LATENCY - 2;

  // Per-rank pipeline storage, index = rank number.
  // dvd_quo_reg holds the not-yet-consumed dividend bits in its upper part and
  // the quotient bits produced so far in its lower part; after the last step
  // it is exactly the quotient magnitude.
  logic [WIDTH-1:0] dvd_quo_reg [0:DIV_STAGES];
  logic [WIDTH-1:0] rem_reg     [0:DIV_STAGES];
  logic [WIDTH-1:0] bmag_reg    [0:DIV_STAGES-1];
  logic [WIDTH-1:0] a_orig_reg  [0:DIV_STAGES];
  logic [TAG_W-1:0] tag_reg     [0:DIV_STAGES];
  logic             q_neg_reg   [0:DIV_STAGES];
  logic             r_neg_reg   [0:DIV_STAGES];
  logic             dbz_reg     [0:DIV_STAGES];
  logic             valid_reg   [0:DIV_STAGES];

  // ------------------------------------------------------------------ rank 0
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  always_comb begin
    a_neg = sdiv.__call_sdiv_signed & sdiv.__call_sdiv_args_0[WIDTH-1];
    b_neg = sdiv.__call_sdiv_signed & sdiv.__call_sdiv_args_1[WIDTH-1];
    // Negating the most negative value yields 2^(WIDTH-1), which is the
    // correct unsigned magnitude, so no special case is needed.
    a_mag = a_neg ? -sdiv.__call_sdiv_args_0 : sdiv.__call_sdiv_args_0;
    b_mag = b_neg ? -sdiv.__call_sdiv_args_1 : sdiv.__call_sdiv_args_1;
  end

  always_ff @(posedge system_clock) begin
    if (system_reset) begin
      valid_reg[0] <= 1'b0;
    end else begin
      valid_reg[0] <= sdiv.__call_sdiv_req;
    end
    dvd_quo_reg[0] <= a_mag;
    rem_reg[0]     <= '0;
    bmag_reg[0]    <= b_mag;
    a_orig_reg[0]  <= sdiv.__call_sdiv_args_0;
    tag_reg[0]     <= sdiv.__call_sdiv_tag;
    q_neg_reg[0]   <= a_neg ^ b_neg;
    r_neg_reg[0]   <= a_neg;
    dbz_reg[0]     <= (sdiv.__call_sdiv_args_1 == '0);
  end

  // ----------------------------------------------------- ranks 1..DIV_STAGES
  for (genvar gi = 1; gi <= DIV_STAGES; gi++) begin : g_step
    logic [WIDTH:0]   shifted_rem;
    logic [WIDTH-1:0] diff;
    logic             fits;

    always_comb begin
      shifted_rem = {rem_reg[gi-1], dvd_quo_reg[gi-1][WIDTH-1]};
      fits        = (shifted_rem >= {1'b0, bmag_reg[gi-1]});
      // When the divisor fits, the difference is below the divisor and so
      // always fits in WIDTH bits.
      diff        = shifted_rem[WIDTH-1:0] - bmag_reg[gi-1];
    end

    always_ff @(posedge system_clock) begin
      if (system_reset) begin
        valid_reg[gi] <= 1'b0;
      end else begin
        valid_reg[gi] <= valid_reg[gi-1];
      end
      rem_reg[gi]     <= fits ? diff : shifted_rem[WIDTH-1:0];
      dvd_quo_reg[gi] <= {dvd_quo_reg[gi-1][WIDTH-2:0], fits};
      a_orig_reg[gi]  <= a_orig_reg[gi-1];
      tag_reg[gi]     <= tag_reg[gi-1];
      q_neg_reg[gi]   <= q_neg_reg[gi-1];
      r_neg_reg[gi]   <= r_neg_reg[gi-1];
      dbz_reg[gi]     <= dbz_reg[gi-1];
    end

    // The divisor is not needed after the last step.
    if (gi < DIV_STAGES) begin : g_fwd_b
      always_ff @(posedge system_clock) begin
        bmag_reg[gi] <= bmag_reg[gi-1];
      end
    end
  end

  // ------------------------------------------------------- sign fix-up rank
  logic [WIDTH-1:0] fin_q_next;
  logic [WIDTH-1:0] fin_r_next;
  logic [WIDTH-1:0] qmag;
  logic [WIDTH-1:0] rmag;

  always_comb begin
    qmag = dvd_quo_reg[DIV_STAGES];
    rmag = rem_reg[DIV_STAGES];
    // MIN / -1 falls out naturally: qmag = 2^(WIDTH-1), and its negation
    // wraps back to MIN.
    if (dbz_reg[DIV_STAGES]) begin
      fin_q_next = '1;
      fin_r_next = a_orig_reg[DIV_STAGES];
    end else begin
      fin_q_next = q_neg_reg[DIV_STAGES] ? -qmag : qmag;
      fin_r_next = r_neg_reg[DIV_STAGES] ? -rmag : rmag;
    end
  end

  logic             fin_valid_reg;
  logic [WIDTH-1:0] fin_q_reg;
  logic [WIDTH-1:0] fin_r_reg;
  logic             fin_dbz_reg;
  logic [TAG_W-1:0] fin_tag_reg;

  always_ff @(posedge system_clock) begin
    if (system_reset) begin
      fin_valid_reg <= 1'b0;
    end else begin
      fin_valid_reg <= valid_reg[DIV_STAGES];
    end
    fin_q_reg   <= fin_q_next;
    fin_r_reg   <= fin_r_next;
    fin_dbz_reg <= dbz_reg[DIV_STAGES];
    fin_tag_reg <= tag_reg[DIV_STAGES];
  end

  // ---------------------------------------------------------- output rank
  logic             done_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] r_reg;
  logic             dbz_out_reg;
  logic [TAG_W-1:0] tag_out_reg;

  always_ff @(posedge system_clock) begin
    if (system_reset) begin
      done_reg    <= 1'b0;
      q_reg       <= '0;
      r_reg       <= '0;
      dbz_out_reg <= 1'b0;
      tag_out_reg <= '0;
    end else begin
      done_reg <= fin_valid_reg;
      // Results hold between completions.
      if (fin_valid_reg) begin
        q_reg       <= fin_q_reg;
        r_reg       <= fin_r_reg;
        dbz_out_reg <= fin_dbz_reg;
        tag_out_reg <= fin_tag_reg;
      end
    end
  end

  assign sdiv.__call_sdiv_ready   = 1'b1;
  assign sdiv.__call_sdiv_done    = done_reg;
  assign sdiv.__call_sdiv_q       = q_reg;
  assign sdiv.__call_sdiv_r       = r_reg;
  assign sdiv.__call_sdiv_dbz     = dbz_out_reg;
  assign sdiv.__call_sdiv_tag_out = tag_out_reg;

endmodule

// File: doc/synverll_sdiv_pipe.md
Name: synverll_sdiv_pipe

Overview:
Parametrised, fully pipelined integer divider for synverll-generated datapaths. It accepts one divide per clock and returns quotient, remainder, divide-by-zero flag and a caller tag after a fixed latency.
- Each operation selects signed or unsigned mode.
- Signed results follow C semantics: quotient truncates toward zero; remainder takes the dividend's sign.
- Sits behind the HLS `__call_sdiv_*` call interface, replacing fixed-width divider instances.

Parameters:
WIDTH, 32, operand/result width in bits (range 4..64)
TAG_W, 4, width of caller tag carried alongside each operation (minimum 1)
LATENCY, WIDTH+2 (derived, localparam), cycles from req sample to done

Ports:
system_clock  in  1  clock; all logic on rising edge
system_reset  in  1  synchronous, active-high reset
__call_sdiv_req  in  1  operation valid this cycle
__call_sdiv_ready  out  1  constant 1; no backpressure
__call_sdiv_signed  in  1  1 = two's-complement operands, 0 = unsigned
__call_sdiv_args_0  in  WIDTH  dividend
__call_sdiv_args_1  in  WIDTH  divisor
__call_sdiv_tag  in  TAG_W  caller tag, returned unchanged
__call_sdiv_done  out  1  result valid, one-cycle pulse per operation
__call_sdiv_q  out  WIDTH  quotient
__call_sdiv_r  out  WIDTH  remainder
__call_sdiv_dbz  out  1  divisor was zero
__call_sdiv_tag_out  out  TAG_W  tag of the completing operation

Behaviour:
- Reset (system_reset=1 at a rising edge) clears all pipeline valid bits and all output registers.
  - done=0, q=0, r=0, dbz=0, tag_out=0 from the next cycle.
  - Operations in flight when reset is asserted are discarded and never produce done.
- Inputs are sampled at an edge where req=1. done for that operation is high exactly LATENCY edges later, for one cycle.
- Back-to-back req produce back-to-back done, in order. There is no stall input and ready is always 1.
- Stage 0 (input register) latches:
  - |a| and |b|, each WIDTH bits. Take magnitudes only when signed=1 and the MSB is set. The magnitude of the most negative value is 2^(WIDTH-1) as an unsigned WIDTH-bit value, with no overflow.
  - q_neg = signed & (a_msb ^ b_msb).
  - r_neg = signed & a_msb.
  - dbz = (b==0).
  - original dividend, tag, valid.
- Stages 1..WIDTH: restoring radix-2.
  - Each stage shifts the partial remainder (WIDTH+1 bits) left, bringing in the next dividend MSB.
  - It trial-subtracts |b| and keeps the result if non-negative, setting the quotient bit.
  - Each stage registers the partial remainder, partial quotient and sidebands.
- Final stage: conditional two's-complement negation.
  - q = q_neg ? -qmag : qmag; r = r_neg ? -rmag : rmag.
  - Arithmetic is mod 2^WIDTH.
- Divide-by-zero overrides the computed values: q = all ones, r = original dividend unchanged, dbz=1. This applies in both modes.
- Signed overflow (MIN / -1): q = MIN (wraps), r = 0, dbz=0. No extra flag.
- Valid bits for req=0 cycles propagate as 0. Outputs hold their last values when done=0.
- Datapath registers need no reset; valid, done and the output registers are reset.

Test Plan:
- WIDTH=32, signed=1: a=-7, b=2 -> q=-3 (0xFFFFFFFD), r=-1 (0xFFFFFFFF), done exactly 34 cycles after req; a=7, b=-2 -> q=-3, r=1.
- signed=0: a=0xFFFFFFFF, b=0x10 -> q=0x0FFFFFFF, r=0xF; same operands with signed=1 -> q=0, r=-1.
- Divide by zero: a=0x12345678, b=0 in both modes -> q=0xFFFFFFFF, r=0x12345678, dbz=1; next op with b=3 -> dbz=0.
- Overflow: signed a=0x80000000, b=0xFFFFFFFF -> q=0x80000000, r=0, dbz=0.
- Throughput/order: 100 consecutive random req (random mode and tags, including 0 and MIN operands) -> 100 consecutive done pulses, tags in order, results matching a C reference model.
- Reset mid-flight: issue 5 reqs, assert system_reset for 1 cycle at cycle 10 -> no done for those 5; a req issued after reset completes after LATENCY with correct results; all outputs 0 in the cycle after reset.
